digit_scan_ctrl: RTL
====================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 4, prescaler counter width.
REQ-002 SHALL have parameter DIV_MAX, default 9, terminal prescaler count; dwell per digit is DIV_MAX+1 cycles; DIV_MAX < 2**DIV_W.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable, level.
REQ-006 SHALL have port mask  input  4  digit enable mask; bit i enables digit i.
REQ-007 SHALL have port data  input  16  four nibbles; digit i = data[4i+3:4i].
REQ-008 SHALL have port sel  output  2  current digit index; drives the 2:4 decoder A input.
REQ-009 SHALL have port nibble  output  4  shadowed nibble of digit sel.
REQ-010 SHALL have port valid  output  1  high while scanning.
REQ-011 SHALL have port tick  output  1  one-cycle pulse, high in the first cycle a new sel is visible.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse, high with tick when the scan wraps.

Function
REQ-013 SHALL implement two states: IDLE, SCAN.
REQ-014 IDLE->SCAN SHALL occur on the edge where en=1 and mask!=0: sel<=lowest set mask bit, cnt<=0, shadow<=data, valid<=1; tick and frame_done stay 0.
REQ-015 SCAN->IDLE SHALL occur on any edge where en=0 or mask==0, taking priority over a tick: sel<=0, cnt<=0, valid<=0, tick<=0, frame_done<=0.
REQ-016 In SCAN, cnt SHALL increment each cycle; at cnt==DIV_MAX: cnt<=0, sel<=next index, tick<=1; otherwise tick<=0.
REQ-017 Next index SHALL be the next set mask bit strictly above sel, wrapping to the lowest set bit; mask is sampled on the tick edge.
REQ-018 frame_done<=1 SHALL occur on a tick edge where next index <= current sel (wrap); with a single enabled digit every tick is frame_done.
REQ-019 shadow SHALL reload from data on every frame_done edge and on IDLE->SCAN; data changes mid-frame SHALL NOT affect nibble.
REQ-020 nibble SHALL equal shadow[4*sel+3:4*sel] when valid=1, else 4'h0; no added latency beyond sel.
REQ-021 A digit masked off mid-dwell SHALL remain selected until its dwell ends.
REQ-022 tick and frame_done SHALL never be high for more than one consecutive cycle when DIV_MAX>0; with DIV_MAX=0, tick is high every SCAN cycle after entry.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, sel=0, cnt=0, shadow=0, nibble=0, valid=0, tick=0, frame_done=0, regardless of clk.
REQ-024 After rst_n deasserts, the first possible transition SHALL be the next rising edge meeting REQ-014; reset mid-scan SHALL abandon the frame without a frame_done pulse.

Configuration
REQ-025 Macro BLANK_EN SHALL, when defined, add output blank (1 bit), high in every cycle tick is high and in IDLE, low otherwise; nibble SHALL read 4'h0 while blank=1.
REQ-026 Without BLANK_EN there SHALL be no blank port and nibble follows REQ-020 unchanged.

Verification (DIV_MAX=3 unless stated)
REQ-027 Reset: rst_n=0 asserted mid-cycle during SCAN -> all outputs 0 before next clk edge.
REQ-028 Full scan: mask=4'hF, data=16'h4321, en=1 -> sel 0,1,2,3,0 each held 4 cycles; nibble 1,2,3,4,1; frame_done with return to sel=0 only.
REQ-029 Skip: mask=4'b1010 -> sel 1,3,1,3; frame_done on each 3->1 tick.
REQ-030 Shadow: data changed 16'h4321->16'h8765 while sel=1 -> nibble 3,4 for sel 2,3, then 5 at sel=0 after frame_done.
REQ-031 Stop: en=0 while cnt=3 -> next edge valid=0, sel=0, no tick; mask=0 with en=1 -> stays IDLE.
REQ-032 Single digit: mask=4'b0100 -> sel=2 constant, tick=frame_done=1 every 4th cycle; with BLANK_EN, blank=1 on those cycles and nibble=0.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Multiplexed 4-digit display scan controller: dwell timer, mask-driven digit walk, frame shadowing.
// Optional macro BLANK_EN adds a blank output that suppresses nibble on tick cycles and in IDLE.

// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not scanning; sel/nibble/valid held at zero
// SCAN  | walking enabled digits, DIV_MAX+1 cycles per digit
module digit_scan_ctrl #(
   parameter int DIV_W   = 4,
   parameter int DIV_MAX = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [3:0]  mask,
   input  logic [15:0] data,
   output logic [1:0]  sel,
   output logic [3:0]  nibble,
   output logic        valid,
   output logic        tick,
   output logic        frame_done
`ifdef BLANK_EN
   ,
   output logic        blank
`endif
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state_q;
   logic [1:0]         sel_q;
   logic [DIV_W-1:0]   cnt_q;
   logic [15:0]        shadow_q;
   logic               valid_q;
   logic               tick_q;
   logic               frame_done_q;

   logic [1:0]         low_idx;
   logic [1:0]         next_sel_d;
   logic               wrap;
   logic [3:0]         cur_nib;

   // Descending loops leave the smallest qualifying index as the winner.
   always_comb begin
      low_idx    = 2'd0;
      next_sel_d = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) low_idx = 2'(i);
      end
      next_sel_d = low_idx;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (i > int'(sel_q))) next_sel_d = 2'(i);
      end
   end

   assign wrap = (next_sel_d <= sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= 2'd0;
         cnt_q        <= '0;
         shadow_q     <= 16'h0000;
         valid_q      <= 1'b0;
         tick_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               tick_q       <= 1'b0;
               frame_done_q <= 1'b0;
               if (en && (mask != 4'h0)) begin
                  state_q  <= SCAN;
                  sel_q    <= low_idx;
                  cnt_q    <= '0;
                  shadow_q <= data;
                  valid_q  <= 1'b1;
               end
            end
            SCAN: begin
               // Leaving wins over a pending dwell expiry.
               if (!en || (mask == 4'h0)) begin
                  state_q      <= IDLE;
                  sel_q        <= 2'd0;
                  cnt_q        <= '0;
                  valid_q      <= 1'b0;
                  tick_q       <= 1'b0;
                  frame_done_q <= 1'b0;
               end else if (cnt_q == DIV_W'(DIV_MAX)) begin
                  cnt_q        <= '0;
                  sel_q        <= next_sel_d;
                  tick_q       <= 1'b1;
                  frame_done_q <= wrap;
                  if (wrap) shadow_q <= data;
               end else begin
                  cnt_q        <= cnt_q + 1'b1;
                  tick_q       <= 1'b0;
                  frame_done_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cur_nib    = shadow_q[{sel_q, 2'b00} +: 4];
   assign sel        = sel_q;
   assign valid      = valid_q;
   assign tick       = tick_q;
   assign frame_done = frame_done_q;

`ifdef BLANK_EN
   assign blank  = tick_q | ~valid_q;
   assign nibble = blank ? 4'h0 : cur_nib;
`else
   assign nibble = valid_q ? cur_nib : 4'h0;
`endif

endmodule
